// File: rtl/main_memory_ctrl.sv
// main_memory_ctrl: wait-state backing-store memory behind the cache control FSM.
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   MStrobe   request strobe, sampled only while idle
//   MRW       request type (1 = write, 0 = read)
//   MAddr     word address
//   MDataIn   write data
//   MDataOut  read data, held until the next read completes
//   MReady    one-cycle completion pulse
//   MBusy     high whenever a transaction is in flight
//   ProtoErr  sticky: strobe seen while busy
module main_memory_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MStrobe,
    input  logic              MRW,
    input  logic [ADDR_W-1:0] MAddr,
    input  logic [DATA_W-1:0] MDataIn,
    output logic [DATA_W-1:0] MDataOut,
    output logic              MReady,
    output logic              MBusy,
    output logic              ProtoErr
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;
    state_t              state;
    logic [7:0]          cnt;
    logic                lrw;
    logic [ADDR_W-1:0]   laddr;
    logic [DATA_W-1:0]   ldata;
    logic [DATA_W-1:0]   mem [2**ADDR_W];
    assign MBusy = state != S_IDLE;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            MDataOut <= '0;
            MReady   <= 1'b0;
            ProtoErr <= 1'b0;
            lrw      <= 1'b0;
            laddr    <= '0;
            ldata    <= '0;
        end else begin
            // completion pulse is registered so it lines up exactly with DONE
            MReady <= state == S_ACCESS;
            if (MStrobe && state != S_IDLE)
                ProtoErr <= 1'b1;
            case (state)
                S_IDLE: if (MStrobe) begin
                    lrw   <= MRW;
                    laddr <= MAddr;
                    ldata <= MDataIn;
                    if (WAIT_CYCLES > 0) begin
                        state <= S_WAIT;
                        cnt   <= 8'(WAIT_CYCLES - 1);
                    end else
                        state <= S_ACCESS;
                end
                S_WAIT: begin
                    if (cnt == 8'd0)
                        state <= S_ACCESS;
                    else
                        cnt <= cnt - 8'd1;
                end
                S_ACCESS: begin
                    if (!lrw)
                        MDataOut <= mem[laddr];
                    state <= S_DONE;
                end
                S_DONE: state <= S_IDLE;
            endcase
        end
    end
    // array is not reset; an aborted write never reaches ACCESS so it is dropped
    always_ff @(posedge clk) begin
        if (state == S_ACCESS && lrw)
            mem[laddr] <= ldata;
    end
endmodule

// File: tb/tb_main_memory_ctrl.sv
// tb_main_memory_ctrl: randomized and directed checks of two controller builds against a timing model.
module tb_main_memory_ctrl;
    logic        clk = 0;
    logic        reset = 0;
    logic        strb [2];
    logic        rw   [2];
    logic [7:0]  addr [2];
    logic [31:0] din  [2];
    logic [31:0] dout [2];
    logic        rdy  [2];
    logic        busy [2];
    logic        perr [2];
    int n_cmp = 0;
    int n_bad = 0;
    always #5 clk = ~clk;
    main_memory_ctrl #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(4)) dut0 (
        .clk(clk), .reset(reset), .MStrobe(strb[0]), .MRW(rw[0]), .MAddr(addr[0]),
        .MDataIn(din[0]), .MDataOut(dout[0]), .MReady(rdy[0]), .MBusy(busy[0]), .ProtoErr(perr[0]));
    main_memory_ctrl #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .reset(reset), .MStrobe(strb[1]), .MRW(rw[1]), .MAddr(addr[1]),
        .MDataIn(din[1]), .MDataOut(dout[1]), .MReady(rdy[1]), .MBusy(busy[1]), .ProtoErr(perr[1]));
    function automatic int wc(int i);
        return i == 0 ? 4 : 0;
    endfunction
    // model: a request accepted at edge t0 is accessed at edge t0+W+1 and the block is idle again after edge t0+W+2
    int          e = 0;
    int          t0   [2] = '{-1000, -1000};
    int          endE [2] = '{-1000, -1000};
    logic        p_rw [2];
    logic [7:0]  p_a  [2];
    logic [31:0] p_d  [2];
    logic [31:0] em   [2][256];
    logic [31:0] ed   [2] = '{0, 0};
    logic        ep   [2] = '{0, 0};
    task automatic mreset(int i);
        t0[i] = -1000;
        endE[i] = -1000;
        ed[i] = 0;
        ep[i] = 0;
    endtask
    task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d edge %0d: got %h want %h", nm, i, e, act, exp);
        end
    endtask
    always @(posedge clk) begin
        e++;
        for (int i = 0; i < 2; i++) begin
            if (!reset)
                mreset(i);
            else begin
                if (e == t0[i] + wc(i) + 1) begin
                    if (p_rw[i]) em[i][p_a[i]] = p_d[i];
                    else ed[i] = em[i][p_a[i]];
                end
                if (strb[i]) begin
                    if (e > endE[i]) begin
                        t0[i] = e;
                        endE[i] = e + wc(i) + 2;
                        p_rw[i] = rw[i];
                        p_a[i] = addr[i];
                        p_d[i] = din[i];
                    end else
                        ep[i] = 1;
                end
            end
        end
    end
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset) mreset(i);
            chk("busy", i, 32'(busy[i]), 32'(e < endE[i]));
            chk("ready", i, 32'(rdy[i]), 32'(e == t0[i] + wc(i) + 1));
            chk("dout", i, dout[i], ed[i]);
            chk("perr", i, 32'(perr[i]), 32'(ep[i]));
        end
    end
    task automatic xact(int i, bit w, logic [7:0] a, logic [31:0] d, output int lat);
        @(posedge clk); #2;
        strb[i] = 1; rw[i] = w; addr[i] = a; din[i] = d;
        @(posedge clk); #2;
        strb[i] = 0; rw[i] = !w; addr[i] = a + 8'd1; din[i] = d * 2;
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (rdy[i] === 1'b1) break;
            if (lat > 300) begin
                n_cmp++; n_bad++;
                $display("FAIL ready_timeout inst%0d", i);
                break;
            end
        end
        @(posedge clk);
    endtask
    initial begin
        int lat, pulses;
        for (int i = 0; i < 2; i++) begin
            strb[i] = 1; rw[i] = 1; addr[i] = 8'h00; din[i] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #2 reset = 1;
        @(posedge clk); #2;
        strb[0] = 0; strb[1] = 0;
        @(negedge clk);
        chk("busy_after_release", 0, 32'(busy[0]), 32'd1);
        repeat (8) @(posedge clk);
        fork
            begin
                int l0;
                for (int a = 0; a < 256; a++) xact(0, 1, 8'(a), $urandom, l0);
            end
            begin
                int l1;
                for (int a = 0; a < 256; a++) xact(1, 1, 8'(a), $urandom, l1);
            end
        join
        xact(0, 1, 8'h12, 32'hDEADBEEF, lat);
        chk("wr_latency", 0, lat, 6);
        xact(0, 0, 8'h12, 32'h0, lat);
        chk("rd_latency", 0, lat, 6);
        chk("rd_deadbeef", 0, dout[0], 32'hDEADBEEF);
        xact(0, 1, 8'h05, 32'h11111111, lat);
        xact(0, 0, 8'h05, 32'h0, lat);
        chk("latched_data", 0, dout[0], 32'h11111111);
        xact(0, 0, 8'h06, 32'h0, lat);
        @(posedge clk); #2;
        strb[0] = 1; rw[0] = 0; addr[0] = 8'h12;
        @(posedge clk); #2 strb[0] = 0;
        @(posedge clk); #2 strb[0] = 1;
        @(posedge clk); #2 strb[0] = 0;
        pulses = 0;
        repeat (12) begin @(negedge clk); pulses += int'(rdy[0]); end
        chk("perr_set", 0, 32'(perr[0]), 32'd1);
        chk("perr_one_pulse", 0, pulses, 1);
        xact(0, 1, 8'h20, 32'h0, lat);
        @(posedge clk); #2;
        strb[0] = 1; rw[0] = 1; addr[0] = 8'h20; din[0] = 32'hCAFEF00D;
        @(posedge clk); #2 strb[0] = 0;
        @(posedge clk); #2 reset = 0;
        pulses = 0;
        repeat (2) begin @(negedge clk); pulses += int'(rdy[0]); end
        @(posedge clk); #2 reset = 1;
        repeat (8) begin @(negedge clk); pulses += int'(rdy[0]); end
        chk("abort_no_ready", 0, pulses, 0);
        chk("perr_cleared", 0, 32'(perr[0]), 32'd0);
        xact(0, 0, 8'h20, 32'h0, lat);
        chk("abort_no_write", 0, dout[0], 32'h0);
        xact(1, 0, 8'h12, 32'h0, lat);
        chk("w0_latency", 1, lat, 2);
        xact(1, 1, 8'hFF, 32'hA5A5_0FF0, lat);
        xact(1, 1, 8'h00, 32'h5A5A_F00F, lat);
        xact(1, 0, 8'hFF, 32'h0, lat);
        chk("w0_addr_ff", 1, dout[1], 32'hA5A5_0FF0);
        xact(1, 0, 8'h00, 32'h0, lat);
        chk("w0_addr_00", 1, dout[1], 32'h5A5A_F00F);
        repeat (3000) begin
            @(posedge clk); #2;
            reset = $urandom_range(0, 299) != 0;
            for (int i = 0; i < 2; i++) begin
                strb[i] = $urandom_range(0, 3) == 0;
                rw[i] = 1'($urandom);
                addr[i] = 8'($urandom);
                din[i] = $urandom;
            end
        end
        @(posedge clk); #2;
        reset = 1; strb[0] = 0; strb[1] = 0;
        repeat (10) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/main_memory_ctrl.md
Name: main_memory_ctrl

Overview:
- Backing-store controller that sits directly downstream of the cache control FSM.
- Consumes the cache's memory-side request (MStrobe, MRW, address, write data) and models main-memory latency with a programmable wait-state counter.
- Performs the read or write into an internal word array, then returns read data and a one-cycle MReady completion pulse.
- Gives the cache datapath a deterministic multi-cycle memory to miss into.

Parameters:
ADDR_W, 8, word-address width; array depth is 2**ADDR_W.
DATA_W, 32, data word width.
WAIT_CYCLES, 4, wait states inserted before the array access; legal range 0..255.

Ports:
clk  input  1  system clock, all state updates on rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
MStrobe  input  1  request strobe from the cache; sampled only in IDLE.
MRW  input  1  request type: 1 = write, 0 = read.
MAddr  input  ADDR_W  word address of the request.
MDataIn  input  DATA_W  write data.
MDataOut  output  DATA_W  read data; registered and held until the next read completes.
MReady  output  1  one-cycle completion pulse for reads and writes.
MBusy  output  1  high whenever state != IDLE.
ProtoErr  output  1  sticky flag: MStrobe was seen while busy.

Behaviour:
- Reset is asynchronous and active-low.
  - While reset==0: state=IDLE, counter=0, MDataOut=0, MReady=0, MBusy=0, ProtoErr=0, latched request registers=0.
  - Array contents are NOT reset.
  - Reset mid-transaction aborts it immediately. A pending write is not performed, and no MReady is issued.
- States: IDLE, WAIT, ACCESS, DONE.
- IDLE:
  - MStrobe==1 at an edge latches MRW, MAddr and MDataIn.
  - If WAIT_CYCLES>0: go to WAIT with counter=WAIT_CYCLES-1.
  - If WAIT_CYCLES==0: go directly to ACCESS.
  - MStrobe==0: stay in IDLE.
- WAIT:
  - Counter==0 at an edge: go to ACCESS.
  - Otherwise decrement the counter.
  - WAIT therefore lasts exactly WAIT_CYCLES cycles.
- ACCESS (one cycle):
  - At the edge, a write stores the latched data at the latched address; a read loads array[latched address] into MDataOut.
  - Go to DONE.
- DONE (one cycle):
  - MReady=1; return to IDLE at the next edge.
  - MReady is 0 in all other states.
- Latency: with the strobe sampled at edge E0, MReady is high in the cycle following edge E0+WAIT_CYCLES+1. For the default, that is 6 cycles from strobe to the MReady cycle.
- Back-to-back requests:
  - After DONE the block is in IDLE for at least one cycle before accepting the next request.
  - If MStrobe is held high continuously, a new transaction starts at the first IDLE edge.
- MStrobe==1 at any edge in WAIT, ACCESS or DONE:
  - Ignored; the request is not queued.
  - ProtoErr is set and stays set until reset.
- Inputs (MRW, MAddr, MDataIn) may change freely after the strobe edge; only the latched copies are used.
- MDataOut:
  - Unchanged by writes.
  - Updated only in ACCESS of a read.
  - Read-after-write to the same address returns the newly written data.
- Address wraps naturally at ADDR_W bits; there is no out-of-range condition.
- MBusy is combinationally derived from the state register (glitch-free, registered state).

Test Plan:
- Reset: hold reset=0 for 3 cycles with MStrobe=1 -> MBusy=0, MReady=0, MDataOut=0, ProtoErr=0 throughout; release -> transaction starts at the first edge.
- Write then read, WAIT_CYCLES=4: write 0xDEADBEEF to addr 0x12, then read addr 0x12 -> each MReady pulses exactly one cycle, 6 cycles after its strobe edge; MDataOut=0xDEADBEEF after the read.
- Input change after latch: strobe a write to addr 0x05 with data 0x11111111, then change MAddr to 0x06 and MDataIn to 0x22222222 during WAIT -> a later read of 0x05 returns 0x11111111, and 0x06 is unchanged.
- Protocol error: second MStrobe issued 2 cycles into WAIT -> ProtoErr=1 (sticky), the first transaction completes normally, and only one MReady pulse occurs.
- Reset mid-write: assert reset during WAIT of a write of 0xCAFEF00D to addr 0x20 that had previously held 0x0 -> no MReady; a read of 0x20 after release returns 0x0.
- WAIT_CYCLES=0 build: read strobe -> MReady in the cycle after edge E0+1 (2-cycle latency); address 0xFF followed by 0x00 both access the correct words.
